// File: rtl/spi_sram_pkg.sv
// Shared definitions for the SPI serial-SRAM responder and its master.
package spi_sram_pkg;

  localparam int unsigned ADDR_BITS = 24;
  localparam int unsigned DATA_BITS = 32;
  localparam int unsigned STRB_BITS = DATA_BITS / 8;
  localparam int unsigned CNT_W     = 6;

  localparam logic [7:0] SPI_WRITE_CMD = 8'h02;
  localparam logic [7:0] SPI_READ_CMD  = 8'h03;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CMD     = 3'd1;
  localparam logic [2:0] ST_ADDR    = 3'd2;
  localparam logic [2:0] ST_RD_DATA = 3'd3;
  localparam logic [2:0] ST_WR_DATA = 3'd4;
  localparam logic [2:0] ST_COMMIT  = 3'd5;
  localparam logic [2:0] ST_IGNORE  = 3'd6;

  typedef struct packed {
    logic                 we;
    logic [ADDR_BITS-1:0] addr;
    logic [DATA_BITS-1:0] wdata;
    logic [STRB_BITS-1:0] wstrb;
  } mem_cmd_t;

  // Byte strobes for a write burst length; zero marks an unsupported length.
  function automatic logic [STRB_BITS-1:0] wstrb_for(input logic [CNT_W-1:0] nbits);
    case (nbits)
      CNT_W'(8):  return 4'b1000;
      CNT_W'(16): return 4'b1100;
      CNT_W'(32): return 4'b1111;
      default:    return 4'b0000;
    endcase
  endfunction

  // Left-align the received bits so the first bit lands at [31].
  function automatic logic [DATA_BITS-1:0] align_wdata(input logic [DATA_BITS-1:0] sh,
                                                       input logic [CNT_W-1:0] nbits);
    case (nbits)
      CNT_W'(8):  return {sh[7:0], 24'h000000};
      CNT_W'(16): return {sh[15:0], 16'h0000};
      default:    return sh;
    endcase
  endfunction

endpackage

// File: rtl/spi_sram_responder_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pin with edge detection.
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise_c,
  output logic fall_c
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level  = sync_q[SYNC_STAGES-1];
  assign rise_c = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall_c = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/spi_sram_responder.sv
// SPI serial-SRAM target (0x02 write / 0x03 read, 24-bit address) bridged to a req/ack word port.
module spi_sram_responder
  import spi_sram_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sclk,
  input  logic                 ce,
  input  logic                 si,
  output logic                 so,
  output logic                 so_oe,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [DATA_BITS-1:0] mem_wdata,
  output logic [STRB_BITS-1:0] mem_wstrb,
  input  logic [DATA_BITS-1:0] mem_rdata,
  input  logic                 mem_ack,
  output logic                 err
);

  logic sclk_lvl, sclk_rise_c, sclk_fall_c;
  logic ce_lvl, ce_rise_c, ce_fall_c;
  logic si_lvl, si_rise_c, si_fall_c;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .reset(reset), .din(sclk), .level(sclk_lvl), .rise_c(sclk_rise_c), .fall_c(sclk_fall_c)
  );
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ce (
    .clk(clk), .reset(reset), .din(ce), .level(ce_lvl), .rise_c(ce_rise_c), .fall_c(ce_fall_c)
  );
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_si (
    .clk(clk), .reset(reset), .din(si), .level(si_lvl), .rise_c(si_rise_c), .fall_c(si_fall_c)
  );

  logic unused_edges;
  assign unused_edges = &{1'b0, sclk_lvl, si_rise_c, si_fall_c};

  logic [2:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 is_read_q, is_read_d;
  logic                 rd_valid_q, rd_valid_d;
  mem_cmd_t             cmd_q, cmd_d;
  logic                 req_q, req_d;
  logic                 so_q, so_d;
  logic                 so_oe_q, so_oe_d;
  logic                 err_q, err_d;

  logic                 ack_c;
  logic [DATA_BITS-1:0] shifted_c;
  logic [STRB_BITS-1:0] strb_c;

  assign ack_c     = req_q & mem_ack;
  assign shifted_c = {shreg_q[DATA_BITS-2:0], si_lvl};
  assign strb_c    = wstrb_for(cnt_q);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      shreg_q    <= '0;
      is_read_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      cmd_q      <= '0;
      req_q      <= 1'b0;
      so_q       <= 1'b0;
      so_oe_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      is_read_q  <= is_read_d;
      rd_valid_q <= rd_valid_d;
      cmd_q      <= cmd_d;
      req_q      <= req_d;
      so_q       <= so_d;
      so_oe_q    <= so_oe_d;
      err_q      <= err_d;
    end
  end

  // Next state and registered-output values; req is only released by an ack.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    is_read_d  = is_read_q;
    rd_valid_d = rd_valid_q;
    cmd_d      = cmd_q;
    req_d      = req_q & ~mem_ack;
    so_d       = so_q;
    err_d      = 1'b0;

    if (ce_rise_c) begin
      cnt_d   = '0;
      shreg_d = '0;
    end

    case (state_q)
      ST_IDLE: begin
        if (ce_rise_c) state_d = ST_CMD;
      end
      ST_CMD: begin
        if (ce_fall_c) begin
          state_d = ST_IDLE;
        end else if (sclk_rise_c) begin
          shreg_d = shifted_c;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(7)) begin
            cnt_d = '0;
            if (shifted_c[7:0] == SPI_WRITE_CMD) begin
              state_d   = ST_ADDR;
              is_read_d = 1'b0;
            end else if (shifted_c[7:0] == SPI_READ_CMD) begin
              state_d   = ST_ADDR;
              is_read_d = 1'b1;
            end else begin
              state_d = ST_IGNORE;
              err_d   = 1'b1;
            end
          end
        end
      end
      ST_ADDR: begin
        if (ce_fall_c) begin
          state_d = ST_IDLE;
        end else if (sclk_rise_c) begin
          shreg_d = shifted_c;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(ADDR_BITS - 1)) begin
            cnt_d      = '0;
            cmd_d.addr = shifted_c[ADDR_BITS-1:0];
            if (is_read_q) begin
              cmd_d.we   = 1'b0;
              req_d      = 1'b1;
              rd_valid_d = 1'b0;
              state_d    = ST_RD_DATA;
            end else begin
              state_d = ST_WR_DATA;
            end
          end
        end
      end
      ST_RD_DATA: begin
        if (ack_c) begin
          shreg_d    = mem_rdata;
          rd_valid_d = 1'b1;
        end
        // An abort with the read still outstanding drains it in IGNORE.
        if (ce_fall_c) begin
          state_d = req_d ? ST_IGNORE : ST_IDLE;
        end else if (sclk_fall_c) begin
          if (!rd_valid_q) begin
            so_d  = 1'b0;
            err_d = 1'b1;
          end else if (cnt_q < CNT_W'(DATA_BITS)) begin
            so_d    = shreg_q[DATA_BITS-1];
            shreg_d = {shreg_q[DATA_BITS-2:0], 1'b0};
            cnt_d   = cnt_q + CNT_W'(1);
          end else begin
            so_d = 1'b0;
          end
        end
      end
      ST_WR_DATA: begin
        if (ce_fall_c) begin
          if (strb_c != '0) begin
            cmd_d.we    = 1'b1;
            cmd_d.wstrb = strb_c;
            cmd_d.wdata = align_wdata(shreg_q, cnt_q);
            req_d       = 1'b1;
            state_d     = ST_COMMIT;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end else if (sclk_rise_c) begin
          shreg_d = shifted_c;
          if (cnt_q <= CNT_W'(DATA_BITS)) cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_COMMIT: begin
        if (ce_rise_c) begin
          state_d = ST_IGNORE;
          err_d   = 1'b1;
        end else if (ack_c) begin
          state_d = ST_IDLE;
        end
      end
      ST_IGNORE: begin
        if (!ce_lvl && !req_d) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    so_oe_d = (state_d == ST_RD_DATA);
    if (state_d != ST_RD_DATA) so_d = 1'b0;
  end

  assign so        = so_q;
  assign so_oe     = so_oe_q;
  assign mem_req   = req_q;
  assign mem_we    = cmd_q.we;
  assign mem_addr  = cmd_q.addr;
  assign mem_wdata = cmd_q.wdata;
  assign mem_wstrb = cmd_q.wstrb;
  assign err       = err_q;

endmodule
